// File: rtl/cam_pkg.sv
// Shared constants and types for the CAM lookup-or-insert controller.
// Optional write-verify path is enabled with `define CAM_WRITE_VERIFY_EN.
package cam_pkg;
  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_WAIT,
    ST_ALLOC,
    ST_WRITE,
    ST_VERIFY,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] index;
    logic             evict;
    logic             err;
  } cam_rsp_t;
endpackage

// File: rtl/cam_alloc_picker.sv
// Lowest-free-entry priority encoder with a table-full flag.
// Used by cam_lookup_ctrl (CAM_WRITE_VERIFY_EN has no effect here).
module cam_alloc_picker
  import cam_pkg::*;
(
  input  logic [ENTRIES-1:0] valid_i,
  output logic [IDX_W-1:0]   free_idx_o,
  output logic               full_o
);
  always_comb begin
    free_idx_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) free_idx_o = IDX_W'(i);
    end
    full_o = &valid_i;
  end
endmodule

// File: rtl/cam_lookup_ctrl.sv
// Lookup-or-insert sequencer for a shared CAM: search, then hit response or allocate+write.
// Define CAM_WRITE_VERIFY_EN to read back each written entry and flag mismatches.
module cam_lookup_ctrl
  import cam_pkg::*;
#(
  parameter int CAM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DATA_W-1:0] req_key_i,
  input  logic              flush_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_hit_o,
  output logic [IDX_W-1:0]  rsp_index_o,
  output logic              rsp_evict_o,
  output logic              rsp_err_o,
  output logic [IDX_W:0]    count_o,
  output logic              cam_search_enable_o,
  output logic [DATA_W-1:0] cam_search_data_o,
  input  logic              cam_search_valid_i,
  input  logic [IDX_W-1:0]  cam_search_index_i,
  output logic              cam_write_enable_o,
  output logic [IDX_W-1:0]  cam_write_index_o,
  output logic [DATA_W-1:0] cam_write_data_o,
  output logic              cam_read_enable_o,
  output logic [IDX_W-1:0]  cam_read_index_o,
  input  logic              cam_read_valid_i,
  input  logic [DATA_W-1:0] cam_read_value_i
);
  localparam int CNT_W = $clog2(CAM_LAT + 1) + 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CAM_LAT - 1);
  localparam logic [CNT_W-1:0] LAT_DONE = CNT_W'(CAM_LAT);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

  state_t             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [IDX_W:0]     count_q, count_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [DATA_W-1:0]  key_q, key_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               evict_q, evict_d;
  logic               req_ready_q, req_ready_d;
  logic               search_en_q, search_en_d;
  logic               write_en_q, write_en_d;
  logic               read_en_q, read_en_d;
  logic               rsp_valid_q, rsp_valid_d;
  cam_rsp_t           rsp_q, rsp_d;
  logic [IDX_W-1:0]   free_idx;
  logic               full;

  cam_alloc_picker u_picker (
    .valid_i    (valid_q),
    .free_idx_o (free_idx),
    .full_o     (full)
  );

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    count_d     = count_q;
    rr_d        = rr_q;
    key_d       = key_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    evict_d     = evict_q;
    req_ready_d = req_ready_q;
    search_en_d = 1'b0;
    write_en_d  = 1'b0;
    read_en_d   = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (flush_i) begin
          valid_d = '0;
          count_d = '0;
        end else if (req_valid_i) begin
          key_d       = req_key_i;
          evict_d     = 1'b0;
          search_en_d = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wait_d = wait_q + CNT_W'(1);
        // A hit spends one extra cycle so the bitmap lookup uses the registered index.
        if (wait_q == LAT_LAST) begin
          idx_d = cam_search_index_i;
          if (!cam_search_valid_i) state_d = ST_ALLOC;
        end else if (wait_q == LAT_DONE) begin
          rsp_d.hit   = valid_q[idx_q];
          rsp_d.index = idx_q;
          rsp_d.evict = 1'b0;
          rsp_d.err   = 1'b0;
          if (!valid_q[idx_q]) begin
            valid_d[idx_q] = 1'b1;
            count_d        = count_q + CNT_ONE;
          end
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_ALLOC: begin
        if (full) begin
          idx_d   = rr_q;
          rr_d    = rr_q + IDX_W'(1);
          evict_d = 1'b1;
        end else begin
          idx_d = free_idx;
        end
        write_en_d = 1'b1;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        if (!valid_q[idx_q]) count_d = count_q + CNT_ONE;
        valid_d[idx_q] = 1'b1;
        rsp_d.hit      = 1'b0;
        rsp_d.index    = idx_q;
        rsp_d.evict    = evict_q;
        rsp_d.err      = 1'b0;
`ifdef CAM_WRITE_VERIFY_EN
        read_en_d = 1'b1;
        state_d   = ST_VERIFY;
`else
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
`endif
      end
`ifdef CAM_WRITE_VERIFY_EN
      ST_VERIFY: begin
        if (cam_read_valid_i) begin
          if (cam_read_value_i != key_q) begin
            rsp_d.err      = 1'b1;
            valid_d[idx_q] = 1'b0;
            count_d        = count_q - CNT_ONE;
          end
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      count_q     <= '0;
      rr_q        <= '0;
      key_q       <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      evict_q     <= 1'b0;
      req_ready_q <= 1'b1;
      search_en_q <= 1'b0;
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      rr_q        <= rr_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      evict_q     <= evict_d;
      req_ready_q <= req_ready_d;
      search_en_q <= search_en_d;
      write_en_q  <= write_en_d;
      read_en_q   <= read_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign req_ready_o         = req_ready_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_hit_o           = rsp_q.hit;
  assign rsp_index_o         = rsp_q.index;
  assign rsp_evict_o         = rsp_q.evict;
  assign count_o             = count_q;
  assign cam_search_enable_o = search_en_q;
  assign cam_search_data_o   = key_q;
  assign cam_write_enable_o  = write_en_q;
  assign cam_write_index_o   = idx_q;
  assign cam_write_data_o    = key_q;

`ifdef CAM_WRITE_VERIFY_EN
  assign cam_read_enable_o = read_en_q;
  assign cam_read_index_o  = idx_q;
  assign rsp_err_o         = rsp_q.err;
`else
  logic unused_rd;
  assign unused_rd         = ^{cam_read_valid_i, cam_read_value_i, rsp_q.err, read_en_q};
  assign cam_read_enable_o = 1'b0;
  assign cam_read_index_o  = '0;
  assign rsp_err_o         = 1'b0;
`endif
endmodule
